// File: rtl/pixel_fetch_responder_if.sv
// Bus bundle for pixel_fetch_responder: requester handshake plus frame-memory read port.
interface pixel_fetch_responder_if;
  localparam int unsigned CoordW = 11;
  localparam int unsigned AddrW  = 19;
  localparam int unsigned PixW   = 8;

  logic              read;
  logic [CoordW-1:0] req_x;
  logic [CoordW-1:0] req_y;
  logic              waitrequest;
  logic [PixW-1:0]   pixel;
  logic              frame_done;
  logic              frame_swap;
  logic              mem_rd;
  logic [AddrW-1:0]  mem_addr;
  logic [PixW-1:0]   mem_rdata;

  modport slave (
    input  read, req_x, req_y, frame_swap, mem_rdata,
    output waitrequest, pixel, frame_done, mem_rd, mem_addr
  );

  modport master (
    output read, req_x, req_y, frame_swap, mem_rdata,
    input  waitrequest, pixel, frame_done, mem_rd, mem_addr
  );
endinterface

// File: rtl/pixel_fetch_responder.sv
// Serves single-pixel reads from a fixed-latency frame memory behind a waitrequest handshake.
// Define PIXEL_FETCH_CACHE_EN to compile in a one-entry last-pixel cache.
module pixel_fetch_responder #(
  parameter int unsigned COL_NUM     = 640,
  parameter int unsigned ROW_NUM     = 480,
  parameter int unsigned MEM_LATENCY = 2
) (
  input logic                    clk,
  input logic                    rst,
  pixel_fetch_responder_if.slave bus
);
  localparam int unsigned CoordW = 11;
  localparam int unsigned AddrW  = 19;
  localparam int unsigned PixW   = 8;
  localparam int unsigned CntW   = 3;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t            state, nextState;
  logic [CntW-1:0]   latCnt, latCntNext;
  logic              abortQ, abortNext;
  logic [CoordW-1:0] curX, curY;
  logic              inRange;
  logic              dataValid;
  logic              hit;
  logic [PixW-1:0]   hitData;

  function automatic logic isLast(input logic [CoordW-1:0] x, input logic [CoordW-1:0] y);
    return (32'(x) == COL_NUM - 1) && (32'(y) == ROW_NUM - 1);
  endfunction

  assign inRange   = (32'(bus.req_x) < COL_NUM) && (32'(bus.req_y) < ROW_NUM);
  assign dataValid = (state == WAIT) && (latCnt == CntW'(1));

`ifdef PIXEL_FETCH_CACHE_EN
  logic              cacheValid;
  logic              staleFill;
  logic [CoordW-1:0] tagX, tagY;
  logic [PixW-1:0]   cacheData;

  assign hit     = cacheValid && (bus.req_x == tagX) && (bus.req_y == tagY);
  assign hitData = cacheData;

  // A swap while a read is in flight makes its returning data belong to the old frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cacheValid <= 1'b0;
      staleFill  <= 1'b0;
      tagX       <= '0;
      tagY       <= '0;
      cacheData  <= '0;
    end else begin
      if (state == IDLE && nextState == ISSUE) staleFill <= 1'b0;
      else if (bus.frame_swap)                 staleFill <= 1'b1;
      if (dataValid) begin
        tagX       <= curX;
        tagY       <= curY;
        cacheData  <= bus.mem_rdata;
        cacheValid <= !staleFill && !bus.frame_swap;
      end else if (bus.frame_swap) begin
        cacheValid <= 1'b0;
      end
    end
  end
`else
  logic unusedSwap;

  assign unusedSwap = bus.frame_swap;
  assign hit        = 1'b0;
  assign hitData    = '0;
`endif

  // Next-state logic; a dropped read lets the memory access drain, then skips RESP.
  always_comb begin
    nextState  = state;
    latCntNext = latCnt;
    abortNext  = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.read) nextState = (!inRange || hit) ? RESP : ISSUE;
      end
      ISSUE: begin
        nextState  = WAIT;
        latCntNext = CntW'(MEM_LATENCY);
        abortNext  = !bus.read;
      end
      WAIT: begin
        latCntNext = latCnt - CntW'(1);
        abortNext  = abortQ || !bus.read;
        if (dataValid) nextState = abortNext ? IDLE : RESP;
      end
      RESP: nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= IDLE;
      latCnt          <= '0;
      abortQ          <= 1'b0;
      curX            <= '0;
      curY            <= '0;
      bus.waitrequest <= 1'b1;
      bus.pixel       <= '0;
      bus.frame_done  <= 1'b0;
      bus.mem_rd      <= 1'b0;
      bus.mem_addr    <= '0;
    end else begin
      state           <= nextState;
      latCnt          <= latCntNext;
      abortQ          <= abortNext;
      bus.waitrequest <= (nextState != RESP);
      bus.mem_rd      <= (nextState == ISSUE);
      bus.frame_done  <= 1'b0;
      if (state == IDLE && bus.read) begin
        curX <= bus.req_x;
        curY <= bus.req_y;
      end
      if (state == IDLE && nextState == ISSUE)
        bus.mem_addr <= AddrW'(32'(bus.req_y) * COL_NUM + 32'(bus.req_x));
      // Immediate response: out-of-range returns zero, a cache hit returns stored data.
      if (state == IDLE && nextState == RESP) begin
        bus.pixel      <= inRange ? hitData : '0;
        bus.frame_done <= inRange && isLast(bus.req_x, bus.req_y);
      end
      if (dataValid && nextState == RESP) begin
        bus.pixel      <= bus.mem_rdata;
        bus.frame_done <= isLast(curX, curY);
      end
    end
  end
endmodule

// File: tb/tb_pixel_fetch_responder.sv
// Self-checking bench for pixel_fetch_responder against a frame-memory and cache reference model.
`timescale 1ns/1ps
module tb_pixel_fetch_responder;
  localparam int COLS   = 640;
  localparam int ROWS   = 480;
  localparam int LAT    = 2;
  localparam int PIXELS = COLS * ROWS;
`ifdef PIXEL_FETCH_CACHE_EN
  localparam bit CACHE = 1'b1;
`else
  localparam bit CACHE = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  pixel_fetch_responder_if bus();

  pixel_fetch_responder #(
    .COL_NUM(COLS), .ROW_NUM(ROWS), .MEM_LATENCY(LAT)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  always #5 clk = ~clk;

  // Frame memory: data sampled at mem_rd, presented LAT cycles later, junk otherwise.
  logic [7:0]     memArr [PIXELS];
  logic [LAT-1:0] pipeV = '0;
  logic [7:0]     pipeD [LAT];
  logic [7:0]     junk = 8'h00;

  always @(posedge clk) begin
    pipeV[0] <= bus.mem_rd;
    pipeD[0] <= (int'(bus.mem_addr) < PIXELS) ? memArr[int'(bus.mem_addr)] : 8'h00;
    for (int i = 1; i < LAT; i++) begin
      pipeV[i] <= pipeV[i-1];
      pipeD[i] <= pipeD[i-1];
    end
    junk <= 8'($urandom);
  end
  assign bus.mem_rdata = pipeV[LAT-1] ? pipeD[LAT-1] : junk;

  // Reference model of the responder: memory lookup plus optional one-entry cache.
  bit         mValid = 1'b0;
  int         mX = 0, mY = 0;
  logic [7:0] mData = 8'h00;

  task automatic predict(input int x, input int y, output int lat, output logic [7:0] pix,
                         output int rd, output logic fd);
    bit oor = (x >= COLS) || (y >= ROWS);
    bit hit = !oor && CACHE && mValid && (mX == x) && (mY == y);
    lat = (oor || hit) ? 1 : 2 + LAT;
    pix = oor ? 8'h00 : (hit ? mData : memArr[y*COLS + x]);
    rd  = (oor || hit) ? 0 : 1;
    fd  = !oor && (x == COLS-1) && (y == ROWS-1);
    if (!oor && !hit && CACHE) begin
      mValid = 1'b1; mX = x; mY = y; mData = pix;
    end
  endtask

  // Drives one read starting in the current cycle and records what the DUT did.
  task automatic runRead(input int x, input int y, output int lat, output logic [7:0] pix,
                         output logic fd, output int rdCount, output logic [18:0] addr,
                         output int rdCycle, output bit fdStray);
    lat = -1; pix = 8'h00; fd = 1'b0; rdCount = 0; addr = '0; rdCycle = -1; fdStray = 1'b0;
    bus.read = 1'b1; bus.req_x = 11'(x); bus.req_y = 11'(y);
    for (int c = 0; c <= 12; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      if (bus.mem_rd) begin
        rdCount++; addr = bus.mem_addr;
        if (rdCycle < 0) rdCycle = c;
      end
      if (!bus.waitrequest) begin
        lat = c; pix = bus.pixel; fd = bus.frame_done;
        break;
      end
      if (bus.frame_done) fdStray = 1'b1;
    end
    bus.read = 1'b0;
    @(posedge clk); #1;
    if (bus.frame_done) fdStray = 1'b1;
    if (bus.mem_rd) rdCount++;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus.waitrequest !== 1'b1) begin errors++; $display("FAIL reset_waitrequest: got %0b expected 1", bus.waitrequest); end
    checks++; if (bus.pixel !== 8'h00) begin errors++; $display("FAIL reset_pixel: got %0h expected 0", bus.pixel); end
    checks++; if (bus.frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done: got %0b expected 0", bus.frame_done); end
    checks++; if (bus.mem_rd !== 1'b0) begin errors++; $display("FAIL reset_mem_rd: got %0b expected 0", bus.mem_rd); end
    checks++; if (bus.mem_addr !== 19'd0) begin errors++; $display("FAIL reset_mem_addr: got %0d expected 0", bus.mem_addr); end
    rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (bus.waitrequest !== 1'b1) begin errors++; $display("FAIL post_reset_idle: got %0b expected 1", bus.waitrequest); end
  endtask

  task automatic test_basic();
    int lat, rd, rdc, eLat, eRd; logic [7:0] pix, ePix; logic fd, eFd; logic [18:0] addr; bit stray;
    memArr[2*COLS + 3] = 8'hA5;
    predict(3, 2, eLat, ePix, eRd, eFd);
    runRead(3, 2, lat, pix, fd, rd, addr, rdc, stray);
    checks++; if (lat !== 4) begin errors++; $display("FAIL basic_latency: got %0d expected 4", lat); end
    checks++; if (rdc !== 1) begin errors++; $display("FAIL basic_mem_rd_cycle: got %0d expected 1", rdc); end
    checks++; if (rd !== 1) begin errors++; $display("FAIL basic_mem_rd_count: got %0d expected 1", rd); end
    checks++; if (addr !== 19'd1283) begin errors++; $display("FAIL basic_addr: got %0d expected 1283", addr); end
    checks++; if (pix !== 8'hA5) begin errors++; $display("FAIL basic_pixel: got %0h expected a5", pix); end
    checks++; if (fd !== 1'b0 || stray) begin errors++; $display("FAIL basic_frame_done: got %0b/%0b expected 0/0", fd, stray); end
  endtask

  task automatic test_out_of_range();
    int lat, rd, rdc, eLat, eRd; logic [7:0] pix, ePix; logic fd, eFd; logic [18:0] addr; bit stray;
    int xs [2] = '{640, 0};
    int ys [2] = '{0, 480};
    for (int i = 0; i < 2; i++) begin
      predict(xs[i], ys[i], eLat, ePix, eRd, eFd);
      runRead(xs[i], ys[i], lat, pix, fd, rd, addr, rdc, stray);
      checks++; if (lat !== 1) begin errors++; $display("FAIL oor_latency_%0d: got %0d expected 1", i, lat); end
      checks++; if (pix !== 8'h00) begin errors++; $display("FAIL oor_pixel_%0d: got %0h expected 0", i, pix); end
      checks++; if (rd !== 0) begin errors++; $display("FAIL oor_mem_rd_%0d: got %0d expected 0", i, rd); end
    end
  endtask

  task automatic test_frame_end();
    int lat, rd, rdc, eLat, eRd; logic [7:0] pix, ePix; logic fd, eFd; logic [18:0] addr; bit stray;
    memArr[PIXELS-1] = 8'h3C;
    predict(639, 479, eLat, ePix, eRd, eFd);
    runRead(639, 479, lat, pix, fd, rd, addr, rdc, stray);
    checks++; if (addr !== 19'd307199) begin errors++; $display("FAIL end_addr: got %0d expected 307199", addr); end
    checks++; if (pix !== 8'h3C) begin errors++; $display("FAIL end_pixel: got %0h expected 3c", pix); end
    checks++; if (fd !== 1'b1) begin errors++; $display("FAIL end_frame_done: got %0b expected 1", fd); end
    checks++; if (stray !== 1'b0) begin errors++; $display("FAIL end_frame_done_stray: got %0b expected 0", stray); end
  endtask

  task automatic test_drop();
    int lat, rd, rdc, eLat, eRd, rdSeen = 0; logic [7:0] pix, ePix; logic fd, eFd; logic [18:0] addr;
    bit stray, sawResp = 1'b0;
    bus.read = 1'b1; bus.req_x = 11'd5; bus.req_y = 11'd5;
    @(posedge clk); #1;
    if (bus.mem_rd) rdSeen++;
    @(posedge clk); #1;
    bus.read = 1'b0;
    for (int c = 0; c < 8; c++) begin
      if (!bus.waitrequest) sawResp = 1'b1;
      @(posedge clk); #1;
      if (bus.mem_rd) rdSeen++;
    end
    if (CACHE) begin mValid = 1'b1; mX = 5; mY = 5; mData = memArr[5*COLS + 5]; end
    checks++; if (sawResp !== 1'b0) begin errors++; $display("FAIL drop_no_resp: got %0b expected 0", sawResp); end
    checks++; if (rdSeen !== 1) begin errors++; $display("FAIL drop_mem_rd: got %0d expected 1", rdSeen); end
    predict(5, 5, eLat, ePix, eRd, eFd);
    runRead(5, 5, lat, pix, fd, rd, addr, rdc, stray);
    checks++; if (lat !== eLat) begin errors++; $display("FAIL drop_retry_latency: got %0d expected %0d", lat, eLat); end
    checks++; if (rd !== eRd) begin errors++; $display("FAIL drop_retry_mem_rd: got %0d expected %0d", rd, eRd); end
    checks++; if (pix !== ePix) begin errors++; $display("FAIL drop_retry_pixel: got %0h expected %0h", pix, ePix); end
  endtask

  task automatic test_frame_swap();
    int lat, rd, rdc, eLat, eRd; logic [7:0] pix, ePix; logic fd, eFd; logic [18:0] addr; bit stray;
    predict(2, 2, eLat, ePix, eRd, eFd);
    runRead(2, 2, lat, pix, fd, rd, addr, rdc, stray);
    bus.frame_swap = 1'b1;
    @(posedge clk); #1;
    bus.frame_swap = 1'b0;
    mValid = 1'b0;
    memArr[2*COLS + 2] = ~memArr[2*COLS + 2];
    predict(2, 2, eLat, ePix, eRd, eFd);
    runRead(2, 2, lat, pix, fd, rd, addr, rdc, stray);
    checks++; if (lat !== 2 + LAT) begin errors++; $display("FAIL swap_latency: got %0d expected %0d", lat, 2 + LAT); end
    checks++; if (pix !== ePix) begin errors++; $display("FAIL swap_pixel: got %0h expected %0h", pix, ePix); end
  endtask

  task automatic test_reset_mid();
    int lat, rd, rdc, eLat, eRd; logic [7:0] pix, ePix; logic fd, eFd; logic [18:0] addr; bit stray;
    memArr[1] = 8'h5A;
    predict(1, 0, eLat, ePix, eRd, eFd);
    runRead(1, 0, lat, pix, fd, rd, addr, rdc, stray);
    checks++; if (pix !== 8'h5A) begin errors++; $display("FAIL rstmid_first_pixel: got %0h expected 5a", pix); end
    bus.read = 1'b1; bus.req_x = 11'd7; bus.req_y = 11'd3;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    checks++; if (bus.waitrequest !== 1'b1) begin errors++; $display("FAIL rstmid_waitrequest: got %0b expected 1", bus.waitrequest); end
    checks++; if (bus.pixel !== 8'h00) begin errors++; $display("FAIL rstmid_pixel: got %0h expected 0", bus.pixel); end
    checks++; if (bus.mem_addr !== 19'd0) begin errors++; $display("FAIL rstmid_mem_addr: got %0d expected 0", bus.mem_addr); end
    checks++; if (bus.mem_rd !== 1'b0 || bus.frame_done !== 1'b0) begin errors++; $display("FAIL rstmid_strobes: got %0b/%0b expected 0/0", bus.mem_rd, bus.frame_done); end
    bus.read = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    mValid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++; if (bus.pixel !== 8'h00 || bus.waitrequest !== 1'b1) begin errors++; $display("FAIL rstmid_stale_ignored: got pixel %0h wr %0b expected 0/1", bus.pixel, bus.waitrequest); end
    memArr[1] = 8'hC7;
    predict(1, 0, eLat, ePix, eRd, eFd);
    runRead(1, 0, lat, pix, fd, rd, addr, rdc, stray);
    checks++; if (pix !== 8'hC7) begin errors++; $display("FAIL rstmid_new_pixel: got %0h expected c7", pix); end
    checks++; if (lat !== 2 + LAT) begin errors++; $display("FAIL rstmid_new_latency: got %0d expected %0d", lat, 2 + LAT); end
  endtask

  task automatic test_random();
    int lat, rd, rdc, eLat, eRd; logic [7:0] pix, ePix; logic fd, eFd; logic [18:0] addr; bit stray;
    int x = 10, y = 10;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        bus.frame_swap = 1'b1;
        @(posedge clk); #1;
        bus.frame_swap = 1'b0;
        mValid = 1'b0;
        if (x < COLS && y < ROWS) memArr[y*COLS + x] = 8'($urandom);
      end
      if ($urandom_range(0, 2) != 0) begin
        x = $urandom_range(0, 660);
        y = $urandom_range(0, 500);
        if ($urandom_range(0, 9) == 0) begin x = COLS - 1; y = ROWS - 1; end
      end
      predict(x, y, eLat, ePix, eRd, eFd);
      runRead(x, y, lat, pix, fd, rd, addr, rdc, stray);
      checks++; if (lat !== eLat) begin errors++; $display("FAIL rand_latency (%0d,%0d): got %0d expected %0d", x, y, lat, eLat); end
      checks++; if (pix !== ePix) begin errors++; $display("FAIL rand_pixel (%0d,%0d): got %0h expected %0h", x, y, pix, ePix); end
      checks++; if (rd !== eRd) begin errors++; $display("FAIL rand_mem_rd (%0d,%0d): got %0d expected %0d", x, y, rd, eRd); end
      checks++; if (fd !== eFd || stray) begin errors++; $display("FAIL rand_frame_done (%0d,%0d): got %0b/%0b expected %0b/0", x, y, fd, stray, eFd); end
      if (eRd == 1) begin
        checks++; if (addr !== 19'(y*COLS + x) || rdc !== 1) begin errors++; $display("FAIL rand_addr (%0d,%0d): got %0d@%0d expected %0d@1", x, y, addr, rdc, y*COLS + x); end
      end
    end
  endtask

  initial begin
    bus.read = 1'b0; bus.req_x = '0; bus.req_y = '0; bus.frame_swap = 1'b0;
    rst = 1'b0;
    for (int i = 0; i < PIXELS; i++) memArr[i] = 8'($urandom);
    test_reset();
    test_basic();
    test_out_of_range();
    test_frame_end();
    test_drop();
    test_frame_swap();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pixel_fetch_responder.md
PIXEL_FETCH_RESPONDER -- requirements
Module: pixel_fetch_responder

Interface
REQ-001 Parameter COL_NUM, default 640, frame width in pixels.
REQ-002 Parameter ROW_NUM, default 480, frame height in pixels.
REQ-003 Parameter MEM_LATENCY, default 2, legal 1..4, cycles from mem_rd sampled to mem_rdata valid.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 read  input  1  pixel read request from the edge-detection requester.
REQ-007 req_x  input  11  requested column; must be held stable while waitrequest=1.
REQ-008 req_y  input  11  requested row; must be held stable while waitrequest=1.
REQ-009 waitrequest  output  1  high = stall; transfer completes in the cycle read=1 and waitrequest=0.
REQ-010 pixel  output  8  returned pixel; valid only in the completing cycle.
REQ-011 frame_done  output  1  one-cycle pulse in the completing cycle for (COL_NUM-1, ROW_NUM-1).
REQ-012 frame_swap  input  1  one-cycle pulse: new frame in memory.
REQ-013 mem_rd  output  1  one-cycle memory read strobe.
REQ-014 mem_addr  output  19  linear memory address, valid while mem_rd=1.
REQ-015 mem_rdata  input  8  memory read data, valid MEM_LATENCY cycles after mem_rd.

Function
REQ-016 FSM states: IDLE, ISSUE, WAIT, RESP; waitrequest SHALL be 0 only in RESP.
REQ-017 IDLE: read=1 with req_x<COL_NUM and req_y<ROW_NUM -> ISSUE; read=1 with either coordinate out of range -> RESP with pixel=0, no mem_rd; read=0 -> stay.
REQ-018 ISSUE: mem_rd=1, mem_addr=req_y*COL_NUM+req_x (registered, 19-bit, no truncation for legal coordinates) -> WAIT.
REQ-019 WAIT: down-counter loaded with MEM_LATENCY; captures mem_rdata into pixel on the cycle it is valid -> RESP next cycle.
REQ-020 In-range latency: read first seen in IDLE in cycle n -> mem_rd in n+1 -> waitrequest=0 in n+2+MEM_LATENCY (n+4 at default).
REQ-021 Out-of-range latency: waitrequest=0 in cycle n+1.
REQ-022 RESP lasts exactly one cycle, then IDLE; back-to-back requests SHALL re-enter the FSM from IDLE (no RESP->ISSUE shortcut).
REQ-023 read dropped during ISSUE/WAIT: memory read completes, data discarded, return to IDLE without RESP; read=0 in RESP: no transfer, return to IDLE.
REQ-024 pixel holds its last value outside RESP; frame_done=0 outside RESP.
REQ-025 frame_swap has no effect on a transaction in flight.

Reset
REQ-026 rst=0 SHALL immediately force state IDLE, waitrequest=1, pixel=0, frame_done=0, mem_rd=0, mem_addr=0, latency counter=0, cache invalid.
REQ-027 Reset asserted mid-transaction SHALL abandon it; a mem_rdata arriving after reset release SHALL be ignored.

Configuration
REQ-028 Macro PIXEL_FETCH_CACHE_EN compiles in a one-entry cache (tag = req_x,req_y; data = 8 bits; valid bit).
REQ-029 With PIXEL_FETCH_CACHE_EN: IDLE read hit on valid tag -> RESP next cycle (n+1) with cached data, no mem_rd; every completed memory read updates the cache; frame_swap or reset clears valid.
REQ-030 Without PIXEL_FETCH_CACHE_EN: no cache storage; every in-range read issues mem_rd per REQ-018.

Verification
REQ-031 Reset then read (3,2) with memory returning 0xA5 -> mem_rd in n+1 with mem_addr=1283, waitrequest=0 and pixel=0xA5 in n+4.
REQ-032 Read (640,0), then (0,480) -> each completes in n+1 with pixel=0x00, mem_rd never asserted.
REQ-033 Read (639,479) returning 0x3C -> mem_addr=307199, frame_done=1 only in the completing cycle.
REQ-034 Read (5,5), deassert read in WAIT -> waitrequest stays 1, FSM returns to IDLE; next read (5,5) issues a fresh mem_rd without cache, completes in n+1 with cache.
REQ-035 Assert rst=0 during WAIT -> outputs take REQ-026 values in the same cycle; after release, read (1,0) returns the new memory data, not stale data.
